// File: rtl/noise_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noise_checker_pkg
//  Description : Constants and types shared between the 8-bit LFSR noise
//                generator and its receive-side checker: register width,
//                feedback tap positions (7,5,4,3), checker state encoding
//                and the one-step sequence prediction.
//  Revision    : 1.0  initial release
// ============================================================================
package noise_checker_pkg;

    // LFSR width and feedback taps. Generator and checker must agree on
    // these for the checker to follow the generated sequence.
    localparam int c_lfsr_w = 8;
    localparam int c_tap_a  = 7;
    localparam int c_tap_b  = 5;
    localparam int c_tap_c  = 4;
    localparam int c_tap_d  = 3;

    // Checker state encoding (2-bit).
    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Next bit of the sequence given the last c_lfsr_w bits, newest in
    // bit 0: b[n] = b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4].
    function automatic logic predict(input logic [c_lfsr_w-1:0] hist);
        return hist[c_tap_a] ^ hist[c_tap_b] ^ hist[c_tap_c] ^ hist[c_tap_d];
    endfunction

endpackage : noise_checker_pkg
`default_nettype wire

// File: rtl/noise_checker.sv
`default_nettype none
// ============================================================================
//  Module      : noise_checker
//  Description : Receive-side checker for the 8-bit maximal-length LFSR
//                noise stream. Collects 8 bits of history, hunts for
//                LOCK_COUNT consecutive correct predictions, then tracks
//                the sequence with a flywheel history and counts bit errors.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock
//    reset      in   synchronous, active-high reset
//    en         in   sample strobe, one din bit consumed per cycle with en=1
//    din        in   received noise bit (generator q[0])
//    err_clr    in   synchronous clear of err_count (wins over an increment)
//    locked     out  high while in LOCKED
//    bit_err    out  one-cycle pulse after a mismatching sample while LOCKED
//    err_count  out  saturating count of bit_err events
// ============================================================================
module noise_checker
    import noise_checker_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 din,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 bit_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int c_fill_w = $clog2(c_lfsr_w);
    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_errs_w = $clog2(LOSS_THRESH + 1);

    // Terminal values: the counter is at "last" when the current sample
    // is the one that completes the run.
    localparam logic [c_fill_w-1:0]  c_fill_last = c_fill_w'(c_lfsr_w - 1);
    localparam logic [c_good_w-1:0]  c_good_last = c_good_w'(LOCK_COUNT - 1);
    localparam logic [c_errs_w-1:0]  c_errs_last = c_errs_w'(LOSS_THRESH - 1);
    localparam logic [ERR_CNT_W-1:0] c_cnt_max   = '1;

    state_t                r_state;
    logic [c_lfsr_w-1:0]   r_hist;
    logic [c_fill_w-1:0]   r_fill;
    logic [c_good_w-1:0]   r_good;
    logic [c_errs_w-1:0]   r_errs;

    logic                  w_pred;
    logic                  w_miss;
    logic [c_lfsr_w-1:0]   w_hist_rx;
    logic [c_lfsr_w-1:0]   w_hist_fly;
    logic                  w_count_err;

    assign w_pred      = predict(r_hist);
    assign w_miss      = (din != w_pred);
    // History advanced with the received bit (SEED/HUNT) or with the
    // predicted bit (LOCKED), so a corrupted bit never enters the history
    // once locked.
    assign w_hist_rx   = {r_hist[c_lfsr_w-2:0], din};
    assign w_hist_fly  = {r_hist[c_lfsr_w-2:0], w_pred};
    assign w_count_err = en && (r_state == LOCKED) && w_miss;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
            r_hist  <= '0;
            r_fill  <= '0;
            r_good  <= '0;
            r_errs  <= '0;
            locked  <= 1'b0;
            bit_err <= 1'b0;
        end else begin
            bit_err <= 1'b0;
            if (en) begin
                case (r_state)
                    SEED: begin
                        r_hist <= w_hist_rx;
                        if (r_fill == c_fill_last) begin
                            r_fill  <= '0;
                            r_good  <= '0;
                            r_state <= HUNT;
                        end else begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end

                    HUNT: begin
                        r_hist <= w_hist_rx;
                        // An all-zero history predicts 0 forever, so it is
                        // never accepted as a match (stuck-at-0 guard).
                        if (!w_miss && (w_hist_rx != '0)) begin
                            if (r_good == c_good_last) begin
                                r_good  <= '0;
                                r_errs  <= '0;
                                locked  <= 1'b1;
                                r_state <= LOCKED;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end

                    LOCKED: begin
                        if (w_miss) begin
                            bit_err <= 1'b1;
                            r_good  <= '0;
                            if (r_errs == c_errs_last) begin
                                r_state <= SEED;
                                r_fill  <= '0;
                                r_hist  <= '0;
                                r_errs  <= '0;
                                locked  <= 1'b0;
                            end else begin
                                r_errs <= r_errs + 1'b1;
                                r_hist <= w_hist_fly;
                            end
                        end else begin
                            r_hist <= w_hist_fly;
                            // A full good run forgives earlier errors.
                            if (r_good == c_good_last) begin
                                r_good <= '0;
                                r_errs <= '0;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= SEED;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_good  <= '0;
                        r_errs  <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a same-cycle clear discards the new error.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (w_count_err && (err_count != c_cnt_max)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule : noise_checker
`default_nettype wire

// File: doc/noise_checker.md
Name: noise_checker

Overview:
- Receive-side counterpart of the 8-bit LFSR noise generator. Checks a 1-bit noise stream, as driven onto a GPIO pin, one sample per enable strobe.
- Self-synchronises to the maximal-length sequence with taps 7,5,4,3, declares lock, and counts bit errors.
- Used in loopback bring-up: a generator GPIO output is wired back into this block, and the `en` strobe comes from the same edge-detector strobe that advances the generator.

Parameters:
- LOCK_COUNT, 16: consecutive correct predictions needed in HUNT before entering LOCKED.
- LOSS_THRESH, 4: errors in LOCKED, without an intervening LOCK_COUNT-long good run, that drop lock.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  sample strobe; each cycle with en=1 consumes one bit of din
- din  input  1  received noise bit (generator q[0])
- err_clr  input  1  synchronous clear of err_count
- locked  output  1  high while in LOCKED
- bit_err  output  1  one-cycle pulse, the cycle after an en sample that mismatches while LOCKED
- err_count  output  ERR_CNT_W  saturating count of bit_err events

Behaviour:
- Interface fact: one clock, `clk`. Reset is `reset`, synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=SEED, history s=0, fill=0, good=0, errs=0, locked=0, bit_err=0, err_count=0.
- History s[7:0]: s[0] is the most recent bit. The shift is s <= {s[6:0], b}.
- Prediction: p = s[7]^s[5]^s[4]^s[3]. This matches the generator recurrence b[n] = b[n-8]^b[n-6]^b[n-5]^b[n-4].
- All state and outputs are registered. The result for the sample taken in cycle t is visible in cycle t+1. With en=0, nothing changes and bit_err=0.
- SEED state:
  - Shift din in and increment fill.
  - After the 8th sample, go to HUNT with good=0.
- HUNT state:
  - Shift din in, always using the received bit.
  - If din==p and the new s is nonzero: good++.
  - Otherwise: good=0.
  - When good reaches LOCK_COUNT, go to LOCKED with errs=0, good=0, locked=1.
  - All-zero history never counts as a match, so a stuck-at-0 line never locks.
  - Stuck-at-1 fails naturally, because p=0 when s=8'hFF.
- LOCKED state:
  - Flywheel: shift in p, not din, so a single error does not corrupt the history.
  - If din!=p: bit_err=1, errs++, good=0, and err_count += 1, saturating at all-ones.
  - If din==p: good++. When good reaches LOCK_COUNT, set errs=0 and good=0.
  - When errs reaches LOSS_THRESH, go to SEED (fill=0, s=0) and set locked=0 in the same update.
  - That final error still pulses bit_err and still counts.
- err_clr:
  - Sets err_count=0.
  - If err_clr and a counted error occur in the same cycle, clear wins: the result is 0 and that error is lost from the count.
  - bit_err still pulses in that case.
  - err_clr does not affect state or lock.
- Reset mid-operation: returns to the reset values on the next edge, regardless of en or err_clr.
- en held high continuously is legal and gives one sample per cycle.
- din is assumed already synchronous to clk. Any synchroniser is external.

Decomposition:
- Shared include file holds the tap positions (7,5,4,3) and the LFSR width (8). The generator and checker use the same constants.
- Shared include file holds the state encodings SEED=0, HUNT=1, LOCKED=2 (2-bit).
- No sub-module is required. The prediction XOR and saturating counter are inline.
- The generator's lfsr module is not reused: it has an async reset and lacks the flywheel input.

Test Plan:
- Clean lock:
  - Stimulus: bits from a reference generator seeded 8'd1, en every 4th cycle. First bits are 0,0,0,1,...
  - Required: locked rises the cycle after the 24th en (8 seed + 16 hunt). After 500 bits, err_count=0 and no bit_err pulses.
- Single flip:
  - Stimulus: once locked, invert bit 100.
  - Required: exactly one bit_err pulse the cycle after that en; err_count=1; locked stays 1; bits 101+ produce no errors (flywheel holds).
- Burst loss and relock:
  - Stimulus: invert 4 consecutive bits while locked.
  - Required: 4 bit_err pulses; locked=0 the cycle after the 4th; err_count=4; locked=1 again 24 en samples later.
- Stuck lines:
  - Stimulus: din=0 for 300 samples, then din=1 for 300 samples.
  - Required: locked stays 0 throughout; bit_err never pulses; err_count=0.
- Saturation and clear (ERR_CNT_W=4):
  - Stimulus: 20 isolated flips, each separated by at least 16 good bits.
  - Required: err_count stops at 15 and locked stays 1.
  - Then: err_clr in the same cycle as an error yields err_count=0.
- Reset mid-lock:
  - Stimulus: assert reset for one cycle while locked with err_count=3.
  - Required: next cycle locked=0, err_count=0, bit_err=0; relock after 24 clean samples.
